// File: rtl/uart_txq_ctrl.sv
// uart_txq_ctrl: round-robin write arbiter for two byte sources in front of a
// FIFO, plus a pop/latch/send sequencer feeding a UART transmitter.
module uart_txq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned ADDRW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             fifo_rst_n,
    output logic             fifo_wr_en,
    output logic [WIDTH-1:0] fifo_wr_data,
    input  logic             fifo_full,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_empty,
    input  logic             tx_en,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    output logic [ADDRW-1:0] level
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        LAT  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   prio1;      // set when req1 wins the next contended cycle
    logic   gnt0;
    logic   gnt1;
    logic   pop_go;

    // Round-robin write grant; nothing is granted while full or in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !fifo_full) begin
            if (req0_valid && req1_valid) begin
                gnt0 = !prio1;
                gnt1 = prio1;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign req0_ready   = gnt0;
    assign req1_ready   = gnt1;
    assign fifo_wr_en   = gnt0 | gnt1;
    assign fifo_wr_data = gnt1 ? req1_data : req0_data;
    assign fifo_rst_n   = ~rst;

    // Priority pointer moves only when somebody is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            prio1 <= 1'b0;
        end else if (gnt0) begin
            prio1 <= 1'b1;
        end else if (gnt1) begin
            prio1 <= 1'b0;
        end
    end

    // Read sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read sequencer next-state logic
    always_comb begin
        state_nxt = state;
        pop_go    = tx_en && !fifo_empty;
        case (state)
            IDLE:    if (pop_go) state_nxt = POP;
            POP:     state_nxt = LAT;
            LAT:     state_nxt = SEND;
            SEND:    if (tx_ready) state_nxt = pop_go ? POP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes decoded from the state register, forced low during reset
    assign fifo_rd_en = (state == POP) && !rst;
    assign tx_valid   = (state == SEND) && !rst;

    // Capture the registered FIFO output one cycle after the pop
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= '0;
        end else if (state == LAT) begin
            tx_data <= fifo_rd_data;
        end
    end

    // Occupancy tracking; a write and a pop in the same cycle cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({fifo_wr_en, fifo_rd_en})
                2'b10:   level <= level + ADDRW'(1);
                2'b01:   level <= level - ADDRW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_txq_ctrl.sv
// Bench for uart_txq_ctrl: behavioural FIFO, arbitration vector table,
// hand-written latency/backpressure/reset sequences and a randomized run
// checked against a queue-based reference model.
module tb_uart_txq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned ADDRW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             fifo_rst_n;
    logic             fifo_wr_en;
    logic [WIDTH-1:0] fifo_wr_data;
    logic             fifo_full;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_empty;
    logic             tx_en;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [ADDRW-1:0] level;

    logic             force_full;
    int unsigned      total = 0;
    int unsigned      bad = 0;

    uart_txq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .fifo_rst_n(fifo_rst_n), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .tx_en(tx_en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .level(level)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO with registered read data and DEPTH-1 usable entries
    logic [WIDTH-1:0] fq[$];
    int unsigned      fcnt = 0;
    logic [WIDTH-1:0] frd = '0;

    assign fifo_full    = force_full || (fcnt == DEPTH - 1);
    assign fifo_empty   = (fcnt == 0);
    assign fifo_rd_data = frd;

    always @(posedge clk) begin
        if (!fifo_rst_n) begin
            fq.delete();
            fcnt <= 0;
            frd  <= '0;
        end else begin
            if (fifo_rd_en && fcnt != 0) frd <= fq.pop_front();
            if (fifo_wr_en) fq.push_back(fifo_wr_data);
            fcnt <= fcnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fcnt != 0) ? 1 : 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        tx_en      = 1'b0;
        tx_ready   = 1'b0;
        force_full = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tx(input int maxc);
        int c;
        c = 0;
        while (!tx_valid && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (!tx_valid) chk("tx_wait_timeout", 32'(tx_valid), 32'd1);
    endtask

    task automatic expect_tx(input string name, input logic [WIDTH-1:0] b);
        wait_tx(12);
        chk(name, 32'(tx_data), 32'(b));
        @(negedge clk);
    endtask

    typedef struct {
        logic             v0;
        logic             v1;
        logic             full;
        logic             r0;
        logic             r1;
        logic [WIDTH-1:0] wd;
    } vec_t;

    initial begin
        vec_t             tbl [11];
        logic [WIDTH-1:0] expo[$];
        logic [WIDTH-1:0] expq[$];
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
        logic [WIDTH-1:0] prev_data;
        int               grants;
        int               last;
        int               mlevel;
        bit               e0;
        bit               e1;
        bit               stall_prev;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h10};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h21};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h13};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h14};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h25};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h17};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2A};

        // Reset with requests and tx_en active: nothing may move
        rst = 1'b1;
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tx_en      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("fifo_rst_n_release", 32'(fifo_rst_n), 32'd1);

        // Arbitration vector table, no pops
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            req0_valid = tbl[i].v0;
            req1_valid = tbl[i].v1;
            req0_data  = 8'(8'h10 + i);
            req1_data  = 8'(8'h20 + i);
            force_full = tbl[i].full;
            #1;
            chk($sformatf("vec%0d_ready0", i), 32'(req0_ready), 32'(tbl[i].r0));
            chk($sformatf("vec%0d_ready1", i), 32'(req1_ready), 32'(tbl[i].r1));
            chk($sformatf("vec%0d_wr_en", i), 32'(fifo_wr_en), 32'(tbl[i].r0 | tbl[i].r1));
            if (tbl[i].r0 || tbl[i].r1) begin
                chk($sformatf("vec%0d_wr_data", i), 32'(fifo_wr_data), 32'(tbl[i].wd));
                expo.push_back(tbl[i].wd);
            end
            @(negedge clk);
        end
        idle_inputs();
        chk("vec_level", 32'(level), 32'd7);
        tx_en    = 1'b1;
        tx_ready = 1'b1;
        while (expo.size() != 0) expect_tx("vec_drain", expo.pop_front());
        tx_en = 1'b0;
        @(negedge clk);
        chk("vec_level_drained", 32'(level), 32'd0);

        // Single write and read latency
        do_reset();
        tx_en      = 1'b1;
        tx_ready   = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("single_level1", 32'(level), 32'd1);
        chk("single_idle_rd", 32'(fifo_rd_en), 32'd0);
        @(negedge clk);
        chk("single_pop_rd", 32'(fifo_rd_en), 32'd1);
        chk("single_pop_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("single_lat_rd", 32'(fifo_rd_en), 32'd0);
        chk("single_lat_level", 32'(level), 32'd0);
        chk("single_lat_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        chk("single_send_valid", 32'(tx_valid), 32'd1);
        chk("single_send_data", 32'(tx_data), 32'h41);
        @(negedge clk);
        chk("single_after_valid", 32'(tx_valid), 32'd0);

        // Contention: grants alternate, FIFO order interleaves
        do_reset();
        d0 = 8'h10;
        d1 = 8'h20;
        for (int j = 0; j < 4; j++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_data  = d0;
            req1_data  = d1;
            #1;
            chk($sformatf("cont%0d_ready0", j), 32'(req0_ready), 32'((j % 2) == 0));
            chk($sformatf("cont%0d_ready1", j), 32'(req1_ready), 32'((j % 2) == 1));
            if (req0_ready) d0 = d0 + 8'd1;
            if (req1_ready) d1 = d1 + 8'd1;
            @(negedge clk);
        end
        idle_inputs();
        tx_en    = 1'b1;
        tx_ready = 1'b1;
        expect_tx("cont_order0", 8'h10);
        expect_tx("cont_order1", 8'h20);
        expect_tx("cont_order2", 8'h11);
        expect_tx("cont_order3", 8'h21);

        // Fill: 300 offers, only DEPTH-1 accepted
        do_reset();
        grants = 0;
        for (int j = 0; j < 300; j++) begin
            req0_valid = 1'b1;
            req1_valid = j[0];
            req0_data  = WIDTH'($urandom);
            req1_data  = WIDTH'($urandom);
            #1;
            if (fifo_full) chk("full_ready", 32'({req0_ready, req1_ready}), 32'd0);
            if (req0_ready || req1_ready) grants++;
            @(negedge clk);
        end
        idle_inputs();
        chk("fill_grants", 32'(grants), 32'(DEPTH - 1));
        chk("fill_level", 32'(level), 32'(DEPTH - 1));

        // Backpressure in SEND
        do_reset();
        tx_en      = 1'b1;
        req0_valid = 1'b1;
        req0_data  = 8'h5A;
        @(negedge clk);
        req0_data  = 8'hA5;
        @(negedge clk);
        req0_valid = 1'b0;
        wait_tx(10);
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_data", 32'(tx_data), 32'h5A);
            chk("bp_no_rd", 32'(fifo_rd_en), 32'd0);
            @(negedge clk);
        end
        tx_ready = 1'b1;
        #1;
        chk("bp_release_valid", 32'(tx_valid), 32'd1);
        chk("bp_release_data", 32'(tx_data), 32'h5A);
        @(negedge clk);
        chk("bp_next_pop", 32'(fifo_rd_en), 32'd1);
        chk("bp_next_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_3cyc_valid", 32'(tx_valid), 32'd1);
        chk("bp_3cyc_data", 32'(tx_data), 32'hA5);
        @(negedge clk);
        chk("bp_done_valid", 32'(tx_valid), 32'd0);

        // Write and pop in the same cycle at level 5; tx_en drop mid-pop
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req0_valid = 1'b1;
            req0_data  = 8'(8'h30 + k);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        chk("sim_level5", 32'(level), 32'd5);
        tx_en = 1'b1;
        @(negedge clk);
        chk("sim_pop", 32'(fifo_rd_en), 32'd1);
        req0_valid = 1'b1;
        req0_data  = 8'h35;
        tx_en      = 1'b0;
        #1;
        chk("sim_grant", 32'(req0_ready), 32'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("sim_level_same", 32'(level), 32'd5);
        tx_ready = 1'b1;
        expect_tx("sim_no_abort", 8'h30);
        chk("sim_idle_valid", 32'(tx_valid), 32'd0);
        chk("sim_level_after", 32'(level), 32'd5);

        // Reset pulse while in SEND
        tx_ready = 1'b0;
        tx_en    = 1'b1;
        wait_tx(10);
        rst = 1'b1;
        #1;
        chk("rsend_valid", 32'(tx_valid), 32'd0);
        chk("rsend_fifo_rst_n", 32'(fifo_rst_n), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rsend_level", 32'(level), 32'd0);
        chk("rsend_data", 32'(tx_data), 32'd0);
        tx_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            chk("rsend_no_stale", 32'({tx_valid, fifo_rd_en}), 32'd0);
            @(negedge clk);
        end

        // Randomized run against a queue-based reference model
        do_reset();
        last       = 1;
        mlevel     = 0;
        stall_prev = 1'b0;
        prev_data  = '0;
        expq.delete();
        for (int n = 0; n < 4000; n++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_data  = WIDTH'($urandom);
            req1_data  = WIDTH'($urandom);
            tx_en      = ((n / 500) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
            tx_ready   = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                chk("rnd_stall_valid", 32'(tx_valid), 32'd1);
                chk("rnd_stall_data", 32'(tx_data), 32'(prev_data));
            end
            e0 = 1'b0;
            e1 = 1'b0;
            if (mlevel != DEPTH - 1) begin
                if (req0_valid && req1_valid) begin
                    e0 = (last == 1);
                    e1 = (last == 0);
                end else begin
                    e0 = req0_valid;
                    e1 = req1_valid;
                end
            end
            chk("rnd_ready0", 32'(req0_ready), 32'(e0));
            chk("rnd_ready1", 32'(req1_ready), 32'(e1));
            chk("rnd_level", 32'(level), 32'(mlevel));
            chk("rnd_rd_vs_valid", 32'(fifo_rd_en & tx_valid), 32'd0);
            if (e0) begin
                expq.push_back(req0_data);
                last = 0;
            end
            if (e1) begin
                expq.push_back(req1_data);
                last = 1;
            end
            if (fifo_rd_en) chk("rnd_rd_when_empty", 32'(mlevel == 0), 32'd0);
            if (tx_valid && tx_ready) begin
                if (expq.size() == 0) chk("rnd_tx_spurious", 32'(tx_valid), 32'd0);
                else chk("rnd_tx_data", 32'(tx_data), 32'(expq.pop_front()));
            end
            mlevel     = mlevel + (e0 || e1 ? 1 : 0) - (fifo_rd_en ? 1 : 0);
            stall_prev = tx_valid && !tx_ready;
            prev_data  = tx_data;
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_txq_ctrl.md
UART_TXQ_CTRL -- requirements
Module: uart_txq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of the requester, FIFO and transmitter paths.
REQ-002 Parameter DEPTH, default 256, FIFO depth; usable capacity is DEPTH-1 entries; ADDRW = $clog2(DEPTH).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset. The ports are named clk and rst.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  CPU requester has a byte
- req0_data  in  WIDTH  CPU byte
- req0_ready  out  1  CPU byte accepted this cycle
- req1_valid  in  1  echo requester has a byte
- req1_data  in  WIDTH  echo byte
- req1_ready  out  1  echo byte accepted this cycle
- fifo_rst_n  out  1  active-low FIFO reset, equal to ~rst
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  WIDTH  FIFO write data
- fifo_full  in  1  FIFO full flag
- fifo_rd_en  out  1  FIFO read strobe; FIFO data is registered and valid on the next cycle
- fifo_rd_data  in  WIDTH  FIFO read data
- fifo_empty  in  1  FIFO empty flag
- tx_en  in  1  allows new pops from the FIFO
- tx_valid  out  1  byte presented to the UART transmitter
- tx_data  out  WIDTH  byte to transmit
- tx_ready  in  1  transmitter accepts the byte when tx_valid is also high
- level  out  ADDRW  current FIFO occupancy

Function
REQ-005 Write arbitration SHALL be round-robin between req0 and req1 and combinational within the cycle; at most one grant per cycle.
REQ-006 A grant SHALL require fifo_full=0. When full, req0_ready=req1_ready=0 and fifo_wr_en=0.
REQ-007 When only one requester is valid and the FIFO is not full, that requester SHALL be granted regardless of priority.
REQ-008 When both requesters are valid, the one not granted last SHALL win; after reset, req0 has priority.
REQ-009 The priority pointer SHALL update only on a grant.
REQ-010 fifo_wr_en SHALL equal the OR of the two grants; fifo_wr_data SHALL be the granted requester's data.
REQ-011 The read sequencer SHALL be an FSM with four states:
- IDLE: fifo_rd_en=0, tx_valid=0.
- POP: fifo_rd_en=1 for exactly one cycle.
- LAT: capture fifo_rd_data into the tx_data register.
- SEND: tx_valid=1.
REQ-012 Transition from IDLE to POP SHALL occur when tx_en=1 and fifo_empty=0.
REQ-013 Transition from POP to LAT SHALL be unconditional.
REQ-014 Transition from LAT to SEND SHALL be unconditional.
REQ-015 The FSM SHALL stay in SEND while tx_ready=0. On tx_valid and tx_ready both high:
- go to POP if tx_en=1 and fifo_empty=0;
- otherwise go to IDLE.
REQ-016 Latency from IDLE (with the pop condition true) to tx_valid=1 SHALL be 3 cycles.
REQ-017 Back-to-back sustained throughput SHALL be one byte per 3 cycles when tx_ready is held high.
REQ-018 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-019 Deasserting tx_en SHALL NOT abort a pop already in POP, LAT or SEND; that byte SHALL still be delivered.
REQ-020 level SHALL increment on fifo_wr_en, decrement on fifo_rd_en, and stay unchanged when both occur in the same cycle.
REQ-021 level SHALL never wrap: it stays in the range 0..DEPTH-1 by construction of the full/empty gating.
REQ-022 A simultaneous grant and pop while full SHALL be impossible, because a grant requires not full.

Reset
REQ-023 While rst=1, at the clock edge the block SHALL set:
- FSM to IDLE
- tx_valid=0, tx_data=0
- level=0
- priority pointer to req0
- fifo_wr_en=0, fifo_rd_en=0
- fifo_rst_n=0, so the FIFO resets in the same cycle
REQ-024 Reset asserted mid-operation (any FSM state) SHALL discard the in-flight byte; no tx_valid pulse SHALL follow the reset release.
REQ-025 After rst deasserts, the first grant or pop SHALL be possible on the next cycle.

Verification
REQ-026 Single write: req0_valid=1 with data 0x41 while empty and tx_en=1.
- Expected: req0_ready=1 for one cycle, level goes to 1.
- Expected: tx_valid=1 with tx_data=0x41 three cycles after IDLE sees the FIFO non-empty; level returns to 0 on the pop.
REQ-027 Contention: both requesters continuously valid, req0 bytes 0x10.., req1 bytes 0x20.., tx_en=0.
- Expected: grants alternate req0, req1, req0, ...; FIFO order is 0x10, 0x20, 0x11, 0x21.
REQ-028 Fill: tx_en=0, 300 requests offered.
- Expected: exactly DEPTH-1=255 grants, level=255, both ready signals 0 while full.
REQ-029 Backpressure: tx_ready=0 for 10 cycles in SEND.
- Expected: tx_valid and tx_data stay stable; no further fifo_rd_en.
- Expected: the byte is released on the first cycle tx_ready=1.
REQ-030 Simultaneous events: write and pop in the same cycle at level=5.
- Expected: level stays 5.
REQ-031 Reset mid-SEND: rst pulsed for 1 cycle while in SEND.
- Expected: tx_valid=0, level=0, fifo_rst_n=0 during reset, and no stale byte afterwards.
